// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle MIPS control FSM over a shared req/ready memory port
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module multicycle_control_fsm #(
    parameter int ALUOP_W  = 3,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_read,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_write_eq,
    output logic               pc_write_ne,
    output logic [1:0]         pc_source,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               illegal_op,
    output logic               bus_error
`ifdef INSTR_COUNT_EN
    ,
    output logic [CNT_W-1:0]   instr_count
`endif
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, R_WB, EXEC_I, I_WB, MEM_ADDR, MEM_RD,
        LW_WB, MEM_WR, BRANCH, JUMP, JR, JAL, ERROR
    } state_t;

    state_t             state, nextState;
    logic [WAIT_W-1:0]  waitCnt;
    logic [ALUOP_W-1:0] immAluOp;
    logic               branchNe;
    logic               memState;
    logic               timeout;

    assign memState = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    assign timeout  = memState && !mem_ready && (waitCnt == WAIT_W'(MAX_WAIT - 1));

    always_comb begin
        nextState = state;
        case (state)
            FETCH:    if (mem_ready) nextState = DECODE; else if (timeout) nextState = ERROR;
            DECODE: begin
                case (op)
                    6'h00:                      nextState = (funct == 6'h08) ? JR : EXEC_R;
                    6'h08, 6'h0c, 6'h0d, 6'h0f: nextState = EXEC_I;
                    6'h23, 6'h2b:               nextState = MEM_ADDR;
                    6'h04, 6'h05:               nextState = BRANCH;
                    6'h02:                      nextState = JUMP;
                    6'h03:                      nextState = JAL;
                    default:                    nextState = ERROR;
                endcase
            end
            EXEC_R:   nextState = R_WB;
            EXEC_I:   nextState = I_WB;
            MEM_ADDR: nextState = (op == 6'h23) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) nextState = LW_WB; else if (timeout) nextState = ERROR;
            MEM_WR:   if (mem_ready) nextState = FETCH; else if (timeout) nextState = ERROR;
            R_WB, I_WB, LW_WB, BRANCH, JUMP, JR, JAL: nextState = FETCH;
            ERROR:    nextState = ERROR;
            default:  nextState = ERROR;
        endcase
    end

    always_comb begin
        mem_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0; i_or_d = 1'b0;
        ir_write = 1'b0; pc_write = 1'b0; pc_write_eq = 1'b0; pc_write_ne = 1'b0;
        pc_source = 2'd0; alu_src_a = 1'b0; alu_src_b = 2'd0; alu_op = '0;
        reg_write = 1'b0; reg_dst = 2'd0; mem_to_reg = 2'd0;
        case (state)
            FETCH: begin
                mem_req = 1'b1; mem_read = 1'b1; alu_src_b = 2'd1;
                ir_write = mem_ready; pc_write = mem_ready;
            end
            DECODE:   alu_src_b = 2'd3;
            EXEC_R:   begin alu_src_a = 1'b1; alu_op = ALUOP_W'(3'b111); end
            R_WB:     begin reg_write = 1'b1; reg_dst = 2'd1; end
            EXEC_I:   begin alu_src_a = 1'b1; alu_src_b = 2'd2; alu_op = immAluOp; end
            I_WB:     reg_write = 1'b1;
            MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = 2'd2; alu_op = ALUOP_W'(3'b011); end
            MEM_RD:   begin mem_req = 1'b1; mem_read = 1'b1; i_or_d = 1'b1; end
            LW_WB:    begin reg_write = 1'b1; mem_to_reg = 2'd1; end
            MEM_WR:   begin mem_req = 1'b1; mem_write = 1'b1; i_or_d = 1'b1; end
            BRANCH: begin
                alu_src_a = 1'b1; alu_op = ALUOP_W'(3'b001); pc_source = 2'd1;
                pc_write_eq = !branchNe; pc_write_ne = branchNe;
            end
            JUMP:     begin pc_write = 1'b1; pc_source = 2'd2; end
            JR:       begin pc_write = 1'b1; pc_source = 2'd3; end
            JAL: begin
                pc_write = 1'b1; pc_source = 2'd2;
                reg_write = 1'b1; reg_dst = 2'd2; mem_to_reg = 2'd2;
            end
            default: ;
        endcase
        // Held reset must not issue a memory access or any architectural write.
        if (!reset) begin
            mem_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
            ir_write = 1'b0; pc_write = 1'b0; reg_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= FETCH;
            waitCnt    <= '0;
            immAluOp   <= '0;
            branchNe   <= 1'b0;
            illegal_op <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            state <= nextState;
            if (memState && !mem_ready && !timeout) waitCnt <= waitCnt + 1'b1;
            else                                    waitCnt <= '0;
            // Latch the opcode-dependent controls so later states stay purely Moore.
            if (state == DECODE) begin
                branchNe <= (op == 6'h05);
                case (op)
                    6'h08:   immAluOp <= ALUOP_W'(3'b100);
                    6'h0c:   immAluOp <= ALUOP_W'(3'b110);
                    6'h0d:   immAluOp <= ALUOP_W'(3'b101);
                    6'h0f:   immAluOp <= ALUOP_W'(3'b010);
                    default: immAluOp <= '0;
                endcase
            end
            if (nextState == ERROR && state != ERROR) begin
                if (state == DECODE) illegal_op <= 1'b1;
                else                 bus_error  <= 1'b1;
            end
        end
    end

`ifdef INSTR_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset)                                     instr_count <= '0;
        else if (nextState == FETCH && state != FETCH) instr_count <= instr_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - randomized self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

    localparam int MAXW = 4;
    localparam int CNTW = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_eq, pc_write_ne;
    logic [1:0] pc_source, alu_src_b, reg_dst, mem_to_reg;
    logic       alu_src_a, reg_write, illegal_op, bus_error;
    logic [2:0] alu_op;
`ifdef INSTR_COUNT_EN
    logic [CNTW-1:0] instr_count;
`endif

    multicycle_control_fsm #(.ALUOP_W(3), .MAX_WAIT(MAXW), .CNT_W(CNTW)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_eq(pc_write_eq),
        .pc_write_ne(pc_write_ne), .pc_source(pc_source), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .bus_error(bus_error)
`ifdef INSTR_COUNT_EN
        , .instr_count(instr_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic memReq, memRead, memWrite, iOrD, irWrite, pcWrite, pcWriteEq, pcWriteNe;
        logic [1:0] pcSource;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic       regWrite;
        logic [1:0] regDst, memToReg;
        logic       illegalOp, busError;
    } outs_t;

    typedef enum {K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JR, K_JAL, K_BAD} kind_t;

    outs_t act;
    assign act = {mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_eq,
                  pc_write_ne, pc_source, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
                  mem_to_reg, illegal_op, bus_error};

    int checks = 0;
    int errors = 0;
    int expCount = 0;
    logic [5:0] legalOps [11] = '{6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b,
                                  6'h04, 6'h05, 6'h02, 6'h03};

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive mem_ready, compare every output, advance to just after the next edge.
    task automatic step(input logic rdy, input outs_t e, input string tag);
        mem_ready = rdy;
        #2;
        checkVal(tag, {9'b0, act}, {9'b0, e});
        @(posedge clk);
        #1;
    endtask

    function automatic kind_t kindOf(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h00:                      return (f == 6'h08) ? K_JR : K_R;
            6'h08, 6'h0c, 6'h0d, 6'h0f: return K_I;
            6'h23:                      return K_LW;
            6'h2b:                      return K_SW;
            6'h04:                      return K_BEQ;
            6'h05:                      return K_BNE;
            6'h02:                      return K_J;
            6'h03:                      return K_JAL;
            default:                    return K_BAD;
        endcase
    endfunction

    function automatic outs_t fetchExp(input logic rdy);
        outs_t e = '0;
        e.memReq = 1'b1; e.memRead = 1'b1; e.aluSrcB = 2'd1;
        e.irWrite = rdy; e.pcWrite = rdy;
        return e;
    endfunction

    task automatic errorTail(input logic ill, input logic bus);
        outs_t e;
        for (int i = 0; i < 3; i++) begin
            e = '0; e.illegalOp = ill; e.busError = bus;
            step(1'($urandom), e, "error_frozen");
        end
    endtask

    task automatic doReset(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom);
            @(posedge clk);
            #1;
            checkVal("reset_quiet", {26'b0, mem_req, ir_write, pc_write, reg_write, illegal_op, bus_error}, 32'd0);
        end
`ifdef INSTR_COUNT_EN
        checkVal("reset_count", 32'(instr_count), 32'd0);
`endif
        expCount = 0;
        reset = 1'b1;
    endtask

    // Reference: one instruction as a list of expected output cycles, from fetch to retirement.
    task automatic runInstr(input logic [5:0] o, input logic [5:0] f, input int wf, input int wm);
        outs_t e;
        kind_t k = kindOf(o, f);
        op = 6'($urandom); funct = 6'($urandom);
        if (wf >= MAXW) begin
            for (int i = 0; i < MAXW; i++) step(1'b0, fetchExp(1'b0), "fetch_wait");
            errorTail(1'b0, 1'b1);
            return;
        end
        for (int i = 0; i < wf; i++) step(1'b0, fetchExp(1'b0), "fetch_wait");
        step(1'b1, fetchExp(1'b1), "fetch");
        op = o; funct = f;
        e = '0; e.aluSrcB = 2'd3;
        step(1'($urandom), e, "decode");
        e = '0;
        case (k)
            K_BAD: begin errorTail(1'b1, 1'b0); return; end
            K_R: begin
                e.aluSrcA = 1'b1; e.aluOp = 3'b111; step(1'($urandom), e, "exec_r");
                e = '0; e.regWrite = 1'b1; e.regDst = 2'd1; step(1'($urandom), e, "r_wb");
            end
            K_I: begin
                e.aluSrcA = 1'b1; e.aluSrcB = 2'd2;
                e.aluOp = (o == 6'h08) ? 3'b100 : (o == 6'h0c) ? 3'b110 : (o == 6'h0d) ? 3'b101 : 3'b010;
                step(1'($urandom), e, "exec_i");
                e = '0; e.regWrite = 1'b1; step(1'($urandom), e, "i_wb");
            end
            K_LW, K_SW: begin
                e.aluSrcA = 1'b1; e.aluSrcB = 2'd2; e.aluOp = 3'b011;
                step(1'($urandom), e, "mem_addr");
                e = '0; e.memReq = 1'b1; e.iOrD = 1'b1;
                e.memRead = (k == K_LW); e.memWrite = (k == K_SW);
                if (wm >= MAXW) begin
                    for (int i = 0; i < MAXW; i++) step(1'b0, e, "mem_wait");
                    errorTail(1'b0, 1'b1);
                    return;
                end
                for (int i = 0; i < wm; i++) step(1'b0, e, "mem_wait");
                step(1'b1, e, "mem_done");
                if (k == K_LW) begin
                    e = '0; e.regWrite = 1'b1; e.memToReg = 2'd1; step(1'($urandom), e, "lw_wb");
                end
            end
            K_BEQ, K_BNE: begin
                e.aluSrcA = 1'b1; e.aluOp = 3'b001; e.pcSource = 2'd1;
                e.pcWriteEq = (k == K_BEQ); e.pcWriteNe = (k == K_BNE);
                step(1'($urandom), e, "branch");
            end
            K_J:  begin e.pcWrite = 1'b1; e.pcSource = 2'd2; step(1'($urandom), e, "jump"); end
            K_JR: begin e.pcWrite = 1'b1; e.pcSource = 2'd3; step(1'($urandom), e, "jr"); end
            K_JAL: begin
                e.pcWrite = 1'b1; e.pcSource = 2'd2; e.regWrite = 1'b1;
                e.regDst = 2'd2; e.memToReg = 2'd2;
                step(1'($urandom), e, "jal");
            end
            default: ;
        endcase
        expCount = (expCount + 1) % (1 << CNTW);
`ifdef INSTR_COUNT_EN
        checkVal("instr_count", 32'(instr_count), 32'(expCount));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        outs_t e;
        logic [5:0] ro, rf;
        @(posedge clk);
        #1;
        doReset(2);
        runInstr(6'h00, 6'h20, 0, 0);
        runInstr(6'h23, 6'h00, 0, 3);
        runInstr(6'h03, 6'h00, 0, 0);
        runInstr(6'h2b, 6'h00, 1, 2);
        runInstr(6'h04, 6'h00, 0, 0);
        runInstr(6'h05, 6'h00, 2, 0);
        runInstr(6'h02, 6'h00, 0, 0);
        runInstr(6'h00, 6'h08, 3, 0);
        runInstr(6'h0c, 6'h00, 0, 0);
        runInstr(6'h0d, 6'h00, 0, 0);
        runInstr(6'h0f, 6'h00, 0, 0);
        doReset(1);
        for (int i = 0; i < 5; i++) runInstr(6'h08, 6'h00, 0, 0);
        for (int i = 0; i < 60; i++) begin
            ro = legalOps[$urandom_range(0, 10)];
            rf = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
            runInstr(ro, rf, $urandom_range(0, MAXW - 1), $urandom_range(0, MAXW - 1));
        end

        // Reset while a load is waiting on memory.
        step(1'b1, fetchExp(1'b1), "abort_fetch");
        op = 6'h23;
        e = '0; e.aluSrcB = 2'd3; step(1'b0, e, "abort_decode");
        e = '0; e.aluSrcA = 1'b1; e.aluSrcB = 2'd2; e.aluOp = 3'b011; step(1'b0, e, "abort_addr");
        e = '0; e.memReq = 1'b1; e.memRead = 1'b1; e.iOrD = 1'b1;
        step(1'b0, e, "abort_wait");
        step(1'b0, e, "abort_wait");
        reset = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        checkVal("abort_memreq", {29'b0, mem_req, reg_write, ir_write}, 32'd0);
`ifdef INSTR_COUNT_EN
        checkVal("abort_count", 32'(instr_count), 32'd0);
`endif
        expCount = 0;
        reset = 1'b1;
        runInstr(6'h2b, 6'h00, 0, 0);

        runInstr(6'h3f, 6'h00, 0, 0);
        doReset(1);
        runInstr(6'h08, 6'h00, MAXW, 0);
        doReset(1);
        runInstr(6'h23, 6'h00, 0, MAXW);
        doReset(1);
        runInstr(6'h00, 6'h25, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
